// File: rtl/uc_pkg.sv
// uc_pkg: shared encodings for the RV64 multi-cycle control unit
package uc_pkg;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_REG    = 7'b0110011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_J = 3'd1;
    localparam logic [2:0] IMM_U = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_S = 3'd4;

    localparam logic [1:0] ULA_NAO     = 2'd0;
    localparam logic [1:0] ULA_SOMA    = 2'd1;
    localparam logic [1:0] ULA_SUBTRAI = 2'd2;

    localparam logic [1:0] PC_MAIS4 = 2'd0;
    localparam logic [1:0] PC_IMM   = 2'd1;
    localparam logic [1:0] PC_ULA   = 2'd2;

    localparam logic [1:0] WB_ULA = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;
    localparam logic [1:0] WB_IMM = 2'd3;

    typedef enum logic [2:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC,
        S_MEM,
        S_WB,
        S_TRAP
    } estado_t;

    typedef enum logic [3:0] {
        C_NENHUMA,
        C_LD,
        C_SD,
        C_ADDI,
        C_ADD,
        C_SUB,
        C_BR,
        C_JAL,
        C_JALR,
        C_LUI,
        C_AUIPC
    } classe_t;

    // Branch condition from funct3; the ULA compares rs1 against rs2
    function automatic logic branch_tomado(
        input logic [2:0] funct3,
        input logic       igual,
        input logic       menor,
        input logic       maior_igual_u
    );
        case (funct3)
            3'b000:  return igual;
            3'b001:  return !igual;
            3'b100:  return menor;
            3'b101:  return !menor;
            3'b110:  return !maior_igual_u;
            3'b111:  return maior_igual_u;
            default: return 1'b0;
        endcase
    endfunction
endpackage

// File: rtl/unidade_controle_if.sv
// unidade_controle_if: control unit link to datapath, instruction and data memories
interface unidade_controle_if;
    logic [31:0] instr;
    logic        imem_ready;
    logic        dmem_ready;
    logic        flag_igual;
    logic        flag_menor;
    logic        flag_maior_igual_u;
    logic        ir_load;
    logic        imem_req;
    logic        dmem_req;
    logic        dmem_we;
    logic        WeR;
    logic [2:0]  select_imm;
    logic [1:0]  soma_ou_subtrai;
    logic        usa_imm;
    logic        pc_we;
    logic [1:0]  pc_sel;
    logic [1:0]  wb_sel;
    logic        illegal;

    modport master (
        input  instr, imem_ready, dmem_ready, flag_igual, flag_menor, flag_maior_igual_u,
        output ir_load, imem_req, dmem_req, dmem_we, WeR, select_imm, soma_ou_subtrai,
               usa_imm, pc_we, pc_sel, wb_sel, illegal
    );

    modport slave (
        output instr, imem_ready, dmem_ready, flag_igual, flag_menor, flag_maior_igual_u,
        input  ir_load, imem_req, dmem_req, dmem_we, WeR, select_imm, soma_ou_subtrai,
               usa_imm, pc_we, pc_sel, wb_sel, illegal
    );
endinterface

// File: rtl/unidade_controle_decodificador_instr.sv
// decodificador_instr: opcode/funct3/funct7 to instruction class, immediate type and legality
module decodificador_instr
    import uc_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic [6:0] funct7,
    output classe_t    classe,
    output logic [2:0] select_imm,
    output logic       legal
);
    always_comb begin
        classe = C_NENHUMA;
        select_imm = IMM_I;
        case (opcode)
            OP_LOAD:   classe = (funct3 == 3'b011) ? C_LD : C_NENHUMA;
            OP_STORE: begin
                classe = (funct3 == 3'b011) ? C_SD : C_NENHUMA;
                select_imm = IMM_S;
            end
            OP_IMM:    classe = (funct3 == 3'b000) ? C_ADDI : C_NENHUMA;
            OP_REG:    classe = (funct3 != 3'b000) ? C_NENHUMA :
                                (funct7 == 7'h00) ? C_ADD :
                                (funct7 == 7'h20) ? C_SUB : C_NENHUMA;
            OP_BRANCH: begin
                classe = (funct3[2:1] == 2'b01) ? C_NENHUMA : C_BR;
                select_imm = IMM_B;
            end
            OP_JAL: begin
                classe = C_JAL;
                select_imm = IMM_J;
            end
            OP_JALR:   classe = (funct3 == 3'b000) ? C_JALR : C_NENHUMA;
            OP_LUI: begin
                classe = C_LUI;
                select_imm = IMM_U;
            end
            OP_AUIPC: begin
                classe = C_AUIPC;
                select_imm = IMM_U;
            end
            default: ;
        endcase
    end

    assign legal = classe != C_NENHUMA;
endmodule

// File: rtl/unidade_controle.sv
// unidade_controle: multi-cycle FSM sequencing fetch, decode, execute, memory and write-back
module unidade_controle
    import uc_pkg::*;
(
    input logic               clk,
    input logic               rst,
    unidade_controle_if.master bus
);
    estado_t    estado, prox;
    classe_t    classe;
    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic [4:0] rd;
    logic [2:0] tipo_imm;
    logic       legal;
    logic       tomado;
    logic       ir_load;
    logic       pc_we;
    logic       wer;
    logic       ula_ativa;
    logic       unused_campos;

    decodificador_instr u_dec (
        .opcode     (opcode),
        .funct3     (funct3),
        .funct7     (funct7),
        .classe     (classe),
        .select_imm (tipo_imm),
        .legal      (legal)
    );

    // Register specifiers are consumed by the register bank, not by the control unit
    assign unused_campos = ^bus.instr[24:15];
    assign tomado = branch_tomado(funct3, bus.flag_igual, bus.flag_menor, bus.flag_maior_igual_u);

    always_ff @(posedge clk) begin
        if (rst) begin
            estado <= S_FETCH;
            opcode <= '0;
            funct3 <= '0;
            funct7 <= '0;
            rd <= '0;
        end else begin
            estado <= prox;
            if (ir_load) begin
                opcode <= bus.instr[6:0];
                rd <= bus.instr[11:7];
                funct3 <= bus.instr[14:12];
                funct7 <= bus.instr[31:25];
            end
        end
    end

    always_comb begin
        prox = estado;
        ir_load = 1'b0;
        pc_we = 1'b0;
        wer = 1'b0;
        bus.pc_sel = PC_MAIS4;
        bus.wb_sel = WB_ULA;
        bus.imem_req = 1'b0;
        bus.dmem_req = 1'b0;
        bus.dmem_we = 1'b0;
        bus.illegal = 1'b0;
        case (estado)
            S_FETCH: begin
                bus.imem_req = !rst;
                ir_load = bus.imem_ready && !rst;
                prox = bus.imem_ready ? S_DECODE : S_FETCH;
            end
            S_DECODE: prox = legal ? S_EXEC : S_TRAP;
            S_EXEC: begin
                pc_we = classe == C_BR;
                bus.pc_sel = (classe == C_BR && tomado) ? PC_IMM : PC_MAIS4;
                prox = (classe == C_BR) ? S_FETCH :
                       (classe inside {C_LD, C_SD}) ? S_MEM : S_WB;
            end
            S_MEM: begin
                bus.dmem_req = 1'b1;
                bus.dmem_we = classe == C_SD;
                pc_we = bus.dmem_ready && classe == C_SD;
                prox = !bus.dmem_ready ? S_MEM : (classe == C_SD) ? S_FETCH : S_WB;
            end
            S_WB: begin
                wer = rd != '0;
                pc_we = 1'b1;
                bus.pc_sel = (classe == C_JAL) ? PC_IMM : (classe == C_JALR) ? PC_ULA : PC_MAIS4;
                bus.wb_sel = (classe == C_LD) ? WB_MEM :
                             (classe inside {C_JAL, C_JALR}) ? WB_PC4 :
                             (classe == C_LUI) ? WB_IMM : WB_ULA;
                prox = S_FETCH;
            end
            S_TRAP: bus.illegal = 1'b1;
            default: prox = S_FETCH;
        endcase
    end

    // A reset arriving mid-instruction must never commit architectural state
    assign bus.ir_load = ir_load;
    assign bus.pc_we = pc_we && !rst;
    assign bus.WeR = wer && !rst;

    assign ula_ativa = estado inside {S_EXEC, S_MEM, S_WB};
    assign bus.select_imm = (estado inside {S_DECODE, S_EXEC, S_MEM, S_WB}) ? tipo_imm : IMM_I;
    assign bus.soma_ou_subtrai = !ula_ativa ? ULA_NAO :
                                 (classe inside {C_ADD, C_ADDI, C_LD, C_SD, C_JALR, C_AUIPC}) ? ULA_SOMA :
                                 (classe inside {C_SUB, C_BR}) ? ULA_SUBTRAI : ULA_NAO;
    assign bus.usa_imm = ula_ativa && (classe inside {C_LD, C_SD, C_ADDI, C_JALR});
endmodule

// File: tb/tb_unidade_controle.sv
// tb_unidade_controle: randomized instruction stream checked against a per-instruction behavioural model
module tb_unidade_controle;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int errors = 0;
    int checks = 0;

    unidade_controle_if bus();

    unidade_controle dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef enum {K_ILL, K_ALU_R, K_ADDI, K_LD, K_SD, K_BR, K_JAL, K_JALR, K_LUI, K_AUIPC} kind_t;

    typedef struct {
        int base;
        bit wr;
        bit mem;
        bit st;
        int simm;
        int ula;
        int uimm;
        int wb;
        int pcs;
    } exp_t;

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic kind_t kind_of(input logic [31:0] w);
        logic [2:0] f3;
        logic [6:0] f7;
        f3 = w[14:12];
        f7 = w[31:25];
        case (w[6:0])
            7'b0000011: return (f3 == 3'b011) ? K_LD : K_ILL;
            7'b0100011: return (f3 == 3'b011) ? K_SD : K_ILL;
            7'b0010011: return (f3 == 3'b000) ? K_ADDI : K_ILL;
            7'b0110011: return (f3 == 3'b000 && (f7 == 7'h00 || f7 == 7'h20)) ? K_ALU_R : K_ILL;
            7'b1100011: return (f3 != 3'd2 && f3 != 3'd3) ? K_BR : K_ILL;
            7'b1101111: return K_JAL;
            7'b1100111: return (f3 == 3'b000) ? K_JALR : K_ILL;
            7'b0110111: return K_LUI;
            7'b0010111: return K_AUIPC;
            default:    return K_ILL;
        endcase
    endfunction

    function automatic exp_t expect_of(input kind_t k, input logic [31:0] w);
        exp_t e;
        e = '{default: 0};
        e.base = 4;
        case (k)
            K_ALU_R: begin e.wr = 1; e.ula = w[30] ? 2 : 1; end
            K_ADDI:  begin e.wr = 1; e.ula = 1; e.uimm = 1; end
            K_LD:    begin e.base = 5; e.wr = 1; e.mem = 1; e.ula = 1; e.uimm = 1; e.wb = 1; end
            K_SD:    begin e.mem = 1; e.st = 1; e.simm = 4; e.ula = 1; e.uimm = 1; end
            K_BR:    begin e.base = 3; e.simm = 3; e.ula = 2; end
            K_JAL:   begin e.wr = 1; e.simm = 1; e.wb = 2; e.pcs = 1; end
            K_JALR:  begin e.wr = 1; e.ula = 1; e.uimm = 1; e.wb = 2; e.pcs = 2; end
            K_LUI:   begin e.wr = 1; e.simm = 2; e.wb = 3; end
            K_AUIPC: begin e.wr = 1; e.simm = 2; e.ula = 1; end
            default: ;
        endcase
        return e;
    endfunction

    function automatic int taken(input logic [2:0] f3, input logic [2:0] fl);
        case (f3)
            3'd0: return int'(fl[0]);
            3'd1: return int'(!fl[0]);
            3'd4: return int'(fl[1]);
            3'd5: return int'(!fl[1]);
            3'd6: return int'(!fl[2]);
            default: return int'(fl[2]);
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        logic [2:0] bf [6];
        bf = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
        w = $urandom;
        case ($urandom_range(0, 11))
            0:  begin w[6:0] = 7'b0000011; w[14:12] = 3'b011; end
            1:  begin w[6:0] = 7'b0100011; w[14:12] = 3'b011; end
            2:  begin w[6:0] = 7'b0010011; w[14:12] = 3'b000; end
            3:  begin w[6:0] = 7'b0110011; w[14:12] = 3'b000; w[31:25] = $urandom_range(0, 1) ? 7'h20 : 7'h00; end
            4:  begin w[6:0] = 7'b1100011; w[14:12] = bf[$urandom_range(0, 5)]; end
            5:  w[6:0] = 7'b1101111;
            6:  begin w[6:0] = 7'b1100111; w[14:12] = 3'b000; end
            7:  w[6:0] = 7'b0110111;
            8:  w[6:0] = 7'b0010111;
            9:  begin w[6:0] = 7'b0010011; w[14:12] = 3'b000; w[11:7] = 5'd0; end
            10: begin w[6:0] = 7'b0000011; w[14:12] = 3'b000; end
            default: ;
        endcase
        return w;
    endfunction

    function automatic int all_outputs();
        return int'({bus.ir_load, bus.imem_req, bus.dmem_req, bus.dmem_we, bus.WeR, bus.select_imm,
                     bus.soma_ou_subtrai, bus.usa_imm, bus.pc_we, bus.pc_sel, bus.wb_sel, bus.illegal});
    endfunction

    task automatic drive_idle();
        bus.instr = '0;
        bus.imem_ready = 1'b0;
        bus.dmem_ready = 1'b0;
        bus.flag_igual = 1'b0;
        bus.flag_menor = 1'b0;
        bus.flag_maior_igual_u = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        drive_idle();
        @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_outputs_zero", all_outputs(), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_imem_req", int'(bus.imem_req), 1);
        check("rst_others_zero", all_outputs() & ~(1 << 15), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic trap_phase();
        int n_ill, n_en;
        n_ill = 0;
        n_en = 0;
        for (int c = 0; c < 10; c++) begin
            bus.instr = $urandom;
            bus.imem_ready = 1'($urandom);
            bus.dmem_ready = 1'($urandom);
            bus.flag_igual = 1'($urandom);
            @(negedge clk);
            n_ill += int'(bus.illegal);
            n_en += int'(bus.ir_load | bus.imem_req | bus.dmem_req | bus.dmem_we | bus.WeR | bus.pc_we);
            @(posedge clk);
            #1;
        end
        check("trap_illegal_sticky", n_ill, 10);
        check("trap_enables_off", n_en, 0);
    endtask

    task automatic run(input logic [31:0] w, input int iw, input int dw);
        kind_t k;
        exp_t e;
        string t;
        int n, ms, n_wer, n_pcwe, n_irl, n_dreq, n_dwe, n_ireq, n_ill;
        int pcwe_at, pcsel, wbsel, ula, uimm, simm;
        logic [2:0] fl, fl_ex;
        k = kind_of(w);
        e = expect_of(k, w);
        t = k.name();
        n = (k == K_ILL) ? iw + 2 : iw + e.base + (e.mem ? dw : 0);
        ms = iw + 3;
        n_wer = 0; n_pcwe = 0; n_irl = 0; n_dreq = 0; n_dwe = 0; n_ireq = 0; n_ill = 0;
        pcwe_at = -1; pcsel = -1; wbsel = -1; ula = -1; uimm = -1; simm = -1;
        fl_ex = '0;
        for (int c = 0; c < n; c++) begin
            fl = 3'($urandom);
            if (c == iw + 2) fl_ex = fl;
            bus.flag_igual = fl[0];
            bus.flag_menor = fl[1];
            bus.flag_maior_igual_u = fl[2];
            bus.imem_ready = (c < iw) ? 1'b0 : (c == iw) ? 1'b1 : 1'($urandom);
            bus.instr = (c == iw) ? w : $urandom;
            bus.dmem_ready = (e.mem && c >= ms) ? (c == ms + dw) : 1'($urandom);
            @(negedge clk);
            n_wer += int'(bus.WeR);
            n_irl += int'(bus.ir_load);
            n_dreq += int'(bus.dmem_req);
            n_dwe += int'(bus.dmem_we);
            n_ireq += int'(bus.imem_req);
            n_ill += int'(bus.illegal);
            if (c == iw + 1) simm = int'(bus.select_imm);
            if (bus.pc_we) begin
                n_pcwe++;
                pcwe_at = c;
                pcsel = int'(bus.pc_sel);
            end
            if (c == n - 1) begin
                wbsel = int'(bus.wb_sel);
                ula = int'(bus.soma_ou_subtrai);
                uimm = int'(bus.usa_imm);
            end
            @(posedge clk);
            #1;
        end
        check({t, "_ir_load"}, n_irl, 1);
        check({t, "_imem_req_cycles"}, n_ireq, iw + 1);
        if (k == K_ILL) begin
            check("ILL_pc_we", n_pcwe, 0);
            check("ILL_wer", n_wer, 0);
            trap_phase();
            do_reset();
            return;
        end
        check({t, "_pc_we_count"}, n_pcwe, 1);
        check({t, "_pc_we_cycle"}, pcwe_at, n - 1);
        check({t, "_pc_sel"}, pcsel, (k == K_BR) ? taken(w[14:12], fl_ex) : e.pcs);
        check({t, "_wer_count"}, n_wer, (e.wr && w[11:7] != 5'd0) ? 1 : 0);
        check({t, "_dmem_req_cycles"}, n_dreq, e.mem ? dw + 1 : 0);
        check({t, "_dmem_we_cycles"}, n_dwe, e.st ? dw + 1 : 0);
        check({t, "_select_imm"}, simm, e.simm);
        check({t, "_ula_op"}, ula, e.ula);
        check({t, "_usa_imm"}, uimm, e.uimm);
        if (e.wr) check({t, "_wb_sel"}, wbsel, e.wb);
        check({t, "_illegal"}, n_ill, 0);
        check({t, "_back_in_fetch"}, int'(bus.imem_req), 1);
    endtask

    task automatic mid_mem_reset();
        drive_idle();
        for (int c = 0; c < 4; c++) begin
            bus.imem_ready = (c == 0);
            bus.instr = (c == 0) ? 32'h0000B283 : 32'h0;
            @(negedge clk);
            if (c == 3) check("mm_req_active", int'(bus.dmem_req), 1);
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        @(negedge clk);
        check("mm_req_held_in_rst_cycle", int'(bus.dmem_req), 1);
        check("mm_no_commit_rst_cycle", int'({bus.WeR, bus.pc_we}), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        bus.dmem_ready = 1'b1;
        @(negedge clk);
        check("mm_req_dropped", int'(bus.dmem_req), 0);
        check("mm_no_writeback", int'({bus.WeR, bus.pc_we}), 0);
        check("mm_back_in_fetch", int'(bus.imem_req), 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        do_reset();
        run(32'h00500093, 0, 0);
        run(32'h002081B3, 0, 0);
        run(32'h402081B3, 1, 0);
        run(32'h00208463, 0, 0);
        run(32'h00208463, 2, 0);
        run(32'h0000B283, 0, 3);
        run(32'h0050B423, 0, 1);
        run(32'hFFFFFFFF, 0, 0);
        mid_mem_reset();
        repeat (120) run(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
